// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- 640x480@60 VGA raster timing plus sprite animation pacing.
//
// Ports:
//   vga_clk    in   pixel clock (only clock)
//   reset      in   synchronous, active-high
//   anim_en    in   animation advance enable, sampled combinationally
//   DrawX      out  [9:0] horizontal pixel position (0..799 at default timing)
//   DrawY      out  [9:0] line number (0..524 at default timing)
//   hs, vs     out  sync pulses, active low
//   blank      out  1 = visible pixel
//   frame_tick out  one-cycle pulse on the last pixel of the frame
//   anim_frame out  [3:0] sprite animation frame index
//
// Parameters: ANIM_FRAMES (2..16), ANIM_DIV (1..255). The H_*/V_* timing
// parameters default to standard 640x480 and only need overriding for a
// scaled-down raster.
//
// Optional macro VGA_SYNC_PIPE_EN: register hs/vs/blank one cycle so they
// line up with a registered RGB path. DrawX/DrawY/frame_tick/anim_frame are
// never delayed.
module vga_timing_gen #(
  parameter int ANIM_FRAMES = 6,
  parameter int ANIM_DIV    = 8,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       anim_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_tick,
  output logic [3:0] anim_frame
);

  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [7:0] DIV_LAST = 8'(ANIM_DIV - 1);
  localparam logic [3:0] FRM_LAST = 4'(ANIM_FRAMES - 1);

  logic [9:0] x_q, x_d, y_q, y_d;
  logic [7:0] div_q, div_d;
  logic [3:0] frm_q, frm_d;
  logic       x_wrap, hs_c, vs_c, blank_c;

  always_comb begin
    x_wrap     = (x_q == H_LAST);
    frame_tick = x_wrap && (y_q == V_LAST);

    x_d = x_wrap ? '0 : x_q + 10'd1;
    y_d = y_q;
    if (x_wrap) y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;

    // Divider and frame index only move on an enabled end-of-frame; with
    // ANIM_DIV=1 DIV_LAST is 0 so every enabled tick advances the frame.
    div_d = div_q;
    frm_d = frm_q;
    if (frame_tick && anim_en) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        frm_d = (frm_q == FRM_LAST) ? '0 : frm_q + 4'd1;
      end else begin
        div_d = div_q + 8'd1;
      end
    end

    hs_c    = !((x_q >= HS_BEG) && (x_q < HS_END));
    vs_c    = !((y_q >= VS_BEG) && (y_q < VS_END));
    blank_c = (x_q < H_VIS) && (y_q < V_VIS);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      div_q <= '0;
      frm_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      div_q <= div_d;
      frm_q <= frm_d;
    end
  end

  assign DrawX      = x_q;
  assign DrawY      = y_q;
  assign anim_frame = frm_q;

`ifdef VGA_SYNC_PIPE_EN
  logic hs_q, vs_q, blank_q;

  // Delayed copy of the decode; blank held low in reset so nothing is drawn
  // before the first real pixel reaches the RGB register.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else begin
      hs_q    <= hs_c;
      vs_q    <= vs_c;
      blank_q <= blank_c;
    end
  end

  assign hs    = hs_q;
  assign vs    = vs_q;
  assign blank = blank_q;
`else
  assign hs    = hs_c;
  assign vs    = vs_c;
  assign blank = blank_c;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. A full-size instance covers line timing; two
// scaled-raster instances (24x18 pixel frame) make frame-level and animation
// behaviour reachable in a short run. The reference model is the cycle count
// since reset (n) plus the count of enabled frame ticks (E): position,
// sync/blank windows and the animation index are plain arithmetic on those.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  localparam int FT_F = 800 * 525;
  localparam int HT_S = 24;
  localparam int VT_S = 18;
  localparam int FT_S = HT_S * VT_S;

  logic clk, rst, en;
  logic [9:0] dx_f, dy_f, dx_s, dy_s, dx_1, dy_1;
  logic hs_f, vs_f, bl_f, ft_f, hs_s, vs_s, bl_s, ft_s, hs_1, vs_1, bl_1, ft_1;
  logic [3:0] af_f, af_s, af_1;
  logic [27:0] act_f, act_s, act_1;

  int n, E_f, E_s;
  int tests, fails;

  vga_timing_gen dut_f (
    .vga_clk(clk), .reset(rst), .anim_en(en), .DrawX(dx_f), .DrawY(dy_f),
    .hs(hs_f), .vs(vs_f), .blank(bl_f), .frame_tick(ft_f), .anim_frame(af_f));

  vga_timing_gen #(.ANIM_FRAMES(6), .ANIM_DIV(8),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_s (
    .vga_clk(clk), .reset(rst), .anim_en(en), .DrawX(dx_s), .DrawY(dy_s),
    .hs(hs_s), .vs(vs_s), .blank(bl_s), .frame_tick(ft_s), .anim_frame(af_s));

  vga_timing_gen #(.ANIM_FRAMES(3), .ANIM_DIV(1),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_1 (
    .vga_clk(clk), .reset(rst), .anim_en(en), .DrawX(dx_1), .DrawY(dy_1),
    .hs(hs_1), .vs(vs_1), .blank(bl_1), .frame_tick(ft_1), .anim_frame(af_1));

  assign act_f = {dx_f, dy_f, hs_f, vs_f, bl_f, ft_f, af_f};
  assign act_s = {dx_s, dy_s, hs_s, vs_s, bl_s, ft_s, af_s};
  assign act_1 = {dx_1, dy_1, hs_1, vs_1, bl_1, ft_1, af_1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {x, y, hs, vs, blank, frame_tick, anim_frame} at cycle n_.
  function automatic logic [27:0] expv(int n_, int e, int ht, int vt, int ha,
      int hs0, int hs1, int va, int vs0, int vs1, int dv, int nf);
    int x, y, p, px, py;
    logic h, v, b;
    x = n_ % ht;
    y = (n_ / ht) % vt;
    p = PIPE ? n_ - 1 : n_;
    if (PIPE && n_ == 0) begin
      h = 1'b1; v = 1'b1; b = 1'b0;
    end else begin
      px = p % ht;
      py = (p / ht) % vt;
      h = !(px >= hs0 && px < hs1);
      v = !(py >= vs0 && py < vs1);
      b = (px < ha) && (py < va);
    end
    return {10'(x), 10'(y), h, v, b, (x == ht - 1) && (y == vt - 1),
            4'((e / dv) % nf)};
  endfunction

  function automatic logic [27:0] exp_f();
    return expv(n, E_f, 800, 525, 640, 656, 752, 480, 490, 492, 8, 6);
  endfunction
  function automatic logic [27:0] exp_s();
    return expv(n, E_s, HT_S, VT_S, 16, 18, 22, 12, 14, 16, 8, 6);
  endfunction
  function automatic logic [27:0] exp_1();
    return expv(n, E_s, HT_S, VT_S, 16, 18, 22, 12, 14, 16, 1, 3);
  endfunction

  // Advance one clock; model sees the same inputs the DUT samples.
  task automatic tick();
    if (!rst && en) begin
      if (n % FT_S == FT_S - 1) E_s++;
      if (n % FT_F == FT_F - 1) E_f++;
    end
    @(posedge clk);
    if (rst) begin n = 0; E_s = 0; E_f = 0; end
    else n++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    tick(); tick();
    tests++; if (dx_f !== 10'd0) begin fails++; $display("FAIL reset_DrawX got %0d want 0", dx_f); end
    tests++; if (dy_f !== 10'd0) begin fails++; $display("FAIL reset_DrawY got %0d want 0", dy_f); end
    tests++; if (hs_f !== 1'b1) begin fails++; $display("FAIL reset_hs got %b want 1", hs_f); end
    tests++; if (vs_f !== 1'b1) begin fails++; $display("FAIL reset_vs got %b want 1", vs_f); end
    tests++; if (bl_f !== !PIPE) begin fails++; $display("FAIL reset_blank got %b want %b", bl_f, !PIPE); end
    tests++; if (ft_f !== 1'b0) begin fails++; $display("FAIL reset_frame_tick got %b want 0", ft_f); end
    tests++; if (af_f !== 4'd0) begin fails++; $display("FAIL reset_anim_frame got %0d want 0", af_f); end
    tests++; if (act_s !== exp_s()) begin fails++; $display("FAIL reset_small got %h want %h", act_s, exp_s()); end
  endtask

  task automatic test_line();
    int bad, hs_low, first, y799, y800;
    logic [27:0] ba, be;
    bad = 0; hs_low = 0; first = -1; y799 = -1; y800 = -1; ba = '0; be = '0;
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 1700; i++) begin
      if (act_f !== exp_f()) begin
        if (bad == 0) begin ba = act_f; be = exp_f(); end
        bad++;
      end
      if (n < 800 && hs_f === 1'b0) begin
        hs_low++;
        if (first < 0) first = int'(dx_f);
      end
      if (n == 799) y799 = int'(dy_f);
      if (n == 800) y800 = int'(dy_f);
      tick();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL line_trace %0d bad cycles, first got %h want %h", bad, ba, be); end
    tests++; if (hs_low != 96) begin fails++; $display("FAIL line_hs_width got %0d want 96", hs_low); end
    tests++; if (first != 656 + int'(PIPE)) begin fails++; $display("FAIL line_hs_start got %0d want %0d", first, 656 + int'(PIPE)); end
    tests++; if (y799 != 0) begin fails++; $display("FAIL line_y_before_wrap got %0d want 0", y799); end
    tests++; if (y800 != 1) begin fails++; $display("FAIL line_y_after_wrap got %0d want 1", y800); end
  endtask

  task automatic test_frame();
    int bad, vs_lo, bl_hi, ftc, ftx, fty;
    logic [27:0] ba, be;
    bad = 0; vs_lo = 0; bl_hi = 0; ftc = 0; ftx = -1; fty = -1; ba = '0; be = '0;
    rst = 1'b1; en = 1'b0; tick(); rst = 1'b0;
    for (int i = 0; i < 2 * FT_S; i++) begin
      if (act_s !== exp_s()) begin
        if (bad == 0) begin ba = act_s; be = exp_s(); end
        bad++;
      end
      if (n < FT_S) begin
        if (vs_s === 1'b0) vs_lo++;
        if (bl_s === 1'b1) bl_hi++;
        if (ft_s === 1'b1) begin ftc++; ftx = int'(dx_s); fty = int'(dy_s); end
      end
      tick();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL frame_trace %0d bad cycles, first got %h want %h", bad, ba, be); end
    tests++; if (vs_lo != 2 * HT_S) begin fails++; $display("FAIL frame_vs_width got %0d want %0d", vs_lo, 2 * HT_S); end
    tests++; if (bl_hi != 16 * 12) begin fails++; $display("FAIL frame_blank_count got %0d want 192", bl_hi); end
    tests++; if (ftc != 1) begin fails++; $display("FAIL frame_tick_count got %0d want 1", ftc); end
    tests++; if (ftx != HT_S - 1 || fty != VT_S - 1) begin fails++; $display("FAIL frame_tick_pos got (%0d,%0d) want (23,17)", ftx, fty); end
  endtask

  task automatic test_anim();
    int bad, chg;
    logic [3:0] prev;
    logic [27:0] ba, be;
    bad = 0; chg = 0; ba = '0; be = '0;
    rst = 1'b1; tick(); rst = 1'b0; en = 1'b1;
    prev = af_s;
    for (int i = 0; i < 48 * FT_S + 5; i++) begin
      if (act_s !== exp_s() || act_1 !== exp_1()) begin
        if (bad == 0) begin ba = act_s; be = exp_s(); end
        bad++;
      end
      if (af_s !== prev) chg++;
      prev = af_s;
      tick();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL anim_trace %0d bad cycles, first got %h want %h", bad, ba, be); end
    tests++; if (chg != 6) begin fails++; $display("FAIL anim_steps got %0d want 6", chg); end
    tests++; if (af_s !== 4'd0) begin fails++; $display("FAIL anim_wrap got %0d want 0", af_s); end
    tests++; if (af_1 !== 4'd0) begin fails++; $display("FAIL anim_div1 got %0d want 0", af_1); end
  endtask

  task automatic test_freeze();
    int bad;
    logic [3:0] a_pre, a_post;
    bad = 0; a_pre = 4'hf; a_post = 4'hf;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 21 * FT_S; i++) begin
      en = (n / FT_S < 3) || (n / FT_S > 10);
      if (act_s !== exp_s() || act_1 !== exp_1()) bad++;
      if (n == 16 * FT_S - 1) a_pre = af_s;
      if (n == 16 * FT_S) a_post = af_s;
      tick();
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL freeze_trace %0d bad cycles", bad); end
    tests++; if (a_pre !== 4'd0) begin fails++; $display("FAIL freeze_before_step got %0d want 0", a_pre); end
    tests++; if (a_post !== 4'd1) begin fails++; $display("FAIL freeze_resume_step got %0d want 1", a_post); end
  endtask

  task automatic test_random();
    int bad;
    logic [27:0] ba, be;
    bad = 0; ba = '0; be = '0;
    for (int i = 0; i < 10000; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 1999) == 0);
      if (act_f !== exp_f() || act_s !== exp_s() || act_1 !== exp_1()) begin
        if (bad == 0) begin ba = act_s; be = exp_s(); end
        bad++;
      end
      tick();
    end
    rst = 1'b0;
    tests++; if (bad != 0) begin fails++; $display("FAIL random_trace %0d bad cycles, first got %h want %h", bad, ba, be); end
  endtask

  task automatic test_midreset();
    int guard;
    rst = 1'b1; tick(); rst = 1'b0; en = 1'b1;
    guard = 0;
    while (!(E_s == 32 && n % FT_S == 5 * HT_S + 10) && guard < 20000) begin
      tick(); guard++;
    end
    tests++;
    if (guard >= 20000) begin
      fails++; $display("FAIL midreset_wait timed out got %0d cycles want <20000", guard);
    end else begin
      tests++; if (af_s !== 4'd4 || dx_s !== 10'd10 || dy_s !== 10'd5) begin
        fails++; $display("FAIL midreset_pre got af=%0d x=%0d y=%0d want af=4 x=10 y=5", af_s, dx_s, dy_s);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      tests++; if (dx_s !== 10'd0 || dy_s !== 10'd0) begin fails++; $display("FAIL midreset_pos got (%0d,%0d) want (0,0)", dx_s, dy_s); end
      tests++; if (af_s !== 4'd0) begin fails++; $display("FAIL midreset_anim got %0d want 0", af_s); end
      tests++; if (ft_s !== 1'b0) begin fails++; $display("FAIL midreset_tick got %b want 0", ft_s); end
      tests++; if (dx_f !== 10'd0 || dy_f !== 10'd0) begin fails++; $display("FAIL midreset_full_pos got (%0d,%0d) want (0,0)", dx_f, dy_f); end
    end
  endtask

  initial begin
    tests = 0; fails = 0; n = 0; E_f = 0; E_s = 0;
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    test_reset();
    test_line();
    test_frame();
    test_anim();
    test_freeze();
    test_random();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter ANIM_FRAMES, default 6, the number of sprite animation frames cycled by anim_frame (legal range 2..16).
REQ-002 SHALL have parameter ANIM_DIV, default 8, the number of video frames per animation step (legal range 1..255).
REQ-003 SHALL have port vga_clk, input, 1 bit: the pixel clock, the only clock in the block.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port anim_en, input, 1 bit: animation advance enable.
REQ-006 SHALL have port DrawX, output, 10 bits: current horizontal pixel position, 0..799.
REQ-007 SHALL have port DrawY, output, 10 bits: current line, 0..524.
REQ-008 SHALL have port hs, output, 1 bit: horizontal sync, active low.
REQ-009 SHALL have port vs, output, 1 bit: vertical sync, active low.
REQ-010 SHALL have port blank, output, 1 bit: display enable; 1 = visible pixel, which gates sprite mapper colour output.
REQ-011 SHALL have port frame_tick, output, 1 bit: one-cycle end-of-frame pulse.
REQ-012 SHALL have port anim_frame, output, 4 bits: current sprite animation frame index.

Function
REQ-013 SHALL increment DrawX every vga_clk cycle, wrapping 799->0.
REQ-014 SHALL increment DrawY only in the cycle where DrawX wraps, wrapping 524->0 in the cycle where DrawX wraps at DrawY=524.
REQ-015 SHALL drive hs=0 when DrawX is in 656..751, else 1 (decoded from the current counters, zero latency).
REQ-016 SHALL drive vs=0 when DrawY is in 490..491, else 1.
REQ-017 SHALL drive blank=1 when DrawX<640 and DrawY<480, else 0.
REQ-018 SHALL drive frame_tick=1 only when DrawX=799 and DrawY=524, giving exactly one pulse per 420000 cycles.
REQ-019 SHALL hold an 8-bit divider count, 0..ANIM_DIV-1, that advances only on a frame_tick cycle with anim_en=1.
REQ-020 SHALL, on a frame_tick cycle with anim_en=1 and divider=ANIM_DIV-1, clear the divider and advance anim_frame by 1, wrapping ANIM_FRAMES-1->0.
REQ-021 SHALL hold both the divider and anim_frame when anim_en=0, including across frame_tick.
REQ-022 SHALL, with ANIM_DIV=1, advance anim_frame on every enabled frame_tick.
REQ-023 SHALL treat an anim_en change coincident with frame_tick as taking effect in that same cycle, because anim_en is sampled combinationally.

Reset
REQ-024 SHALL, when reset=1 at a vga_clk edge, set DrawX=0, DrawY=0, divider=0 and anim_frame=0 on that edge.
REQ-025 SHALL have reset-state outputs hs=1, vs=1, blank=1 and frame_tick=0; under VGA_SYNC_PIPE_EN, hs=1, vs=1 and blank=0.
REQ-026 SHALL have reset override anim_en and counter wrap in the same cycle; a reset mid-line or mid-frame restarts the frame at (0,0) on the next cycle.

Configuration
REQ-027 SHALL, with macro VGA_SYNC_PIPE_EN defined, register hs, vs and blank through one vga_clk stage so they align with the sprite mapper's registered RGB; DrawX, DrawY, frame_tick and anim_frame stay undelayed.
REQ-028 SHALL, without VGA_SYNC_PIPE_EN, decode hs, vs and blank with zero latency as in REQ-015..017.

Verification
REQ-029 SHALL be checked by: release reset and run 800 cycles -> DrawX sequence 0..799 then 0; DrawY steps 0->1 exactly at the wrap; hs low for 96 cycles starting at DrawX=656.
REQ-030 SHALL be checked by: run one full frame -> vs low for lines 490..491 (1600 cycles); blank high for 307200 cycles; one frame_tick at (799,524).
REQ-031 SHALL be checked by: ANIM_FRAMES=6, ANIM_DIV=8, anim_en=1, run 48 frames -> anim_frame steps every 8 frame_ticks through 0..5 and returns to 0.
REQ-032 SHALL be checked by: anim_en=0 for frames 3..10 -> anim_frame and divider frozen; on re-enable, counting resumes from the held divider value.
REQ-033 SHALL be checked by: assert reset at DrawX=300, DrawY=200 with anim_frame=4 -> the next cycle shows DrawX=0, DrawY=0, anim_frame=0, frame_tick=0.
REQ-034 SHALL be checked by: with VGA_SYNC_PIPE_EN defined, hs falls one cycle after DrawX=656 and blank falls one cycle after DrawX=640.
